// File: rtl/spi_top_module.sv
// spi_top_module: SPI slave that turns cmd/addr/data frames into async SRAM write/read cycles (SPI_BURST_EN enables bursts).
// Latency: a strobe starts ~3 FPGA_clk after the word's last SCLK fall and lasts MEM_CYCLES clocks; read data leaves on the next SCLK rise.
// Backpressure: none; the master must allow each strobe to finish before the next SCLK rise, and raising SSEL aborts the frame.
module spi_top_module #(
  parameter int MEM_CYCLES = 3
) (
  input  logic        FPGA_clk,
  input  logic        FPGA_rst,
  input  logic        SCLK,
  input  logic        SSEL,
  input  logic        MOSI,
  output logic        MISO,
  inout  wire  [15:0] data_line,
  output logic [19:0] addr_line,
  output logic        chip_en_out,
  output logic        read_en_out,
  output logic        write_en_out,
  output logic        lb_en_out,
  output logic        ub_en_out
);

  localparam int MCW = (MEM_CYCLES > 1) ? $clog2(MEM_CYCLES) : 1;
  localparam logic [MCW-1:0] MEM_LAST = MCW'(MEM_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE, CMD, ADDR, WDATA, WSTROBE, RSTROBE, RSHIFT, DONE
  } state_t;

  logic sclk_s1, sclk_s2, sclk_d;
  logic ssel_s1, ssel_s2, ssel_d;
  logic mosi_s1, mosi_s2;

  state_t         state;
  logic [4:0]     bit_cnt;
  logic [18:0]    rx_sh;
  logic [15:0]    wr_word;
  logic [15:0]    rd_sh;
  logic [MCW-1:0] mem_cnt;
  logic           is_read;
  logic           drive_en;
`ifdef SPI_BURST_EN
  logic [2:0]     words_left;
`endif

  logic        sclk_rise, sclk_fall, ssel_fall;
  logic [19:0] rx_next;

  assign sclk_rise = sclk_s2 & ~sclk_d;
  assign sclk_fall = ~sclk_s2 & sclk_d;
  assign ssel_fall = ~ssel_s2 & ssel_d;
  // Shift register contents with the bit being sampled this cycle appended.
  assign rx_next   = {rx_sh, mosi_s2};

  // The bus is only driven while a write strobe is in flight.
  assign data_line = drive_en ? wr_word : 16'hzzzz;

  // Two-flop synchronizers plus one history flop for edge detection.
  always_ff @(posedge FPGA_clk) begin
    if (FPGA_rst) begin
      sclk_s1 <= 1'b0; sclk_s2 <= 1'b0; sclk_d <= 1'b0;
      ssel_s1 <= 1'b0; ssel_s2 <= 1'b0; ssel_d <= 1'b0;
      mosi_s1 <= 1'b0; mosi_s2 <= 1'b0;
    end else begin
      sclk_s1 <= SCLK;    sclk_s2 <= sclk_s1; sclk_d <= sclk_s2;
      ssel_s1 <= SSEL;    ssel_s2 <= ssel_s1; ssel_d <= ssel_s2;
      mosi_s1 <= MOSI;    mosi_s2 <= mosi_s1;
    end
  end

  // Frame FSM: decode cmd/addr, run memory strobes, shift read data out.
  always_ff @(posedge FPGA_clk) begin
    if (FPGA_rst) begin
      state        <= IDLE;
      bit_cnt      <= '0;
      rx_sh        <= '0;
      wr_word      <= '0;
      rd_sh        <= '0;
      mem_cnt      <= '0;
      is_read      <= 1'b0;
      drive_en     <= 1'b0;
      addr_line    <= '0;
      MISO         <= 1'b0;
      chip_en_out  <= 1'b1;
      read_en_out  <= 1'b1;
      write_en_out <= 1'b1;
      lb_en_out    <= 1'b1;
      ub_en_out    <= 1'b1;
`ifdef SPI_BURST_EN
      words_left   <= '0;
`endif
    end else if (ssel_s2 && state != IDLE) begin
      // Deselect ends the frame at once, cutting any strobe short.
      state        <= IDLE;
      bit_cnt      <= '0;
      mem_cnt      <= '0;
      drive_en     <= 1'b0;
      MISO         <= 1'b0;
      chip_en_out  <= 1'b1;
      read_en_out  <= 1'b1;
      write_en_out <= 1'b1;
      lb_en_out    <= 1'b1;
      ub_en_out    <= 1'b1;
    end else if (ssel_fall) begin
      // New frame always starts at command bit 7.
      state        <= CMD;
      bit_cnt      <= '0;
      rx_sh        <= '0;
      drive_en     <= 1'b0;
      MISO         <= 1'b0;
      chip_en_out  <= 1'b1;
      read_en_out  <= 1'b1;
      write_en_out <= 1'b1;
      lb_en_out    <= 1'b1;
      ub_en_out    <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
        end
        CMD: begin
          if (sclk_fall) begin
            rx_sh <= rx_next[18:0];
            if (bit_cnt == 5'd7) begin
              bit_cnt <= '0;
              // rx_sh[6:4] already holds command bits 7..5.
              if (rx_sh[6:4] == 3'b111 || rx_sh[6:4] == 3'b110) begin
                state   <= ADDR;
                is_read <= (rx_sh[6:4] == 3'b110);
`ifdef SPI_BURST_EN
                words_left <= {rx_sh[1:0], mosi_s2};
`endif
              end else begin
                state <= DONE;
              end
            end else begin
              bit_cnt <= bit_cnt + 5'd1;
            end
          end
        end
        ADDR: begin
          if (sclk_fall) begin
            rx_sh <= rx_next[18:0];
            if (bit_cnt == 5'd23) begin
              bit_cnt   <= '0;
              addr_line <= rx_next;
              if (is_read) begin
                state       <= RSTROBE;
                mem_cnt     <= '0;
                chip_en_out <= 1'b0;
                read_en_out <= 1'b0;
                lb_en_out   <= 1'b0;
                ub_en_out   <= 1'b0;
              end else begin
                state <= WDATA;
              end
            end else begin
              bit_cnt <= bit_cnt + 5'd1;
            end
          end
        end
        WDATA: begin
          if (sclk_fall) begin
            rx_sh <= rx_next[18:0];
            if (bit_cnt == 5'd15) begin
              bit_cnt      <= '0;
              wr_word      <= rx_next[15:0];
              drive_en     <= 1'b1;
              mem_cnt      <= '0;
              state        <= WSTROBE;
              chip_en_out  <= 1'b0;
              write_en_out <= 1'b0;
              lb_en_out    <= 1'b0;
              ub_en_out    <= 1'b0;
            end else begin
              bit_cnt <= bit_cnt + 5'd1;
            end
          end
        end
        WSTROBE: begin
          // Keep collecting the next word in case SCLK runs during the strobe.
          if (sclk_fall) begin
            rx_sh   <= rx_next[18:0];
            bit_cnt <= bit_cnt + 5'd1;
          end
          if (mem_cnt == MEM_LAST) begin
            drive_en     <= 1'b0;
            chip_en_out  <= 1'b1;
            write_en_out <= 1'b1;
            lb_en_out    <= 1'b1;
            ub_en_out    <= 1'b1;
`ifdef SPI_BURST_EN
            if (words_left != 3'd0) begin
              words_left <= words_left - 3'd1;
              addr_line  <= addr_line + 20'd1;
              state      <= WDATA;
            end else begin
              state <= DONE;
            end
`else
            state <= DONE;
`endif
          end else begin
            mem_cnt <= mem_cnt + 1'b1;
          end
        end
        RSTROBE: begin
          if (mem_cnt == MEM_LAST) begin
            rd_sh       <= data_line;
            bit_cnt     <= '0;
            state       <= RSHIFT;
            chip_en_out <= 1'b1;
            read_en_out <= 1'b1;
            lb_en_out   <= 1'b1;
            ub_en_out   <= 1'b1;
          end else begin
            mem_cnt <= mem_cnt + 1'b1;
          end
        end
        RSHIFT: begin
          if (sclk_rise) begin
            MISO  <= rd_sh[15];
            rd_sh <= {rd_sh[14:0], 1'b0};
          end
          if (sclk_fall) begin
            if (bit_cnt == 5'd15) begin
              bit_cnt <= '0;
              MISO    <= 1'b0;
`ifdef SPI_BURST_EN
              if (words_left != 3'd0) begin
                words_left  <= words_left - 3'd1;
                addr_line   <= addr_line + 20'd1;
                mem_cnt     <= '0;
                state       <= RSTROBE;
                chip_en_out <= 1'b0;
                read_en_out <= 1'b0;
                lb_en_out   <= 1'b0;
                ub_en_out   <= 1'b0;
              end else begin
                state <= DONE;
              end
`else
              state <= DONE;
`endif
            end else begin
              bit_cnt <= bit_cnt + 5'd1;
            end
          end
        end
        DONE: begin
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_top_module.sv
// tb_spi_top_module: drives SPI frames into spi_top_module and checks memory cycles and MISO.
// Latency: frame-level; each frame is clocked at 1/20 of FPGA_clk.
// Backpressure: none; the bench acts as SPI master and as the SRAM.
module tb_spi_top_module;

  localparam int MEM_CYCLES = 3;
  localparam int HP = 100;
`ifdef SPI_BURST_EN
  localparam bit BURST = 1'b1;
`else
  localparam bit BURST = 1'b0;
`endif

  logic FPGA_clk = 1'b0;
  logic FPGA_rst, SCLK, SSEL, MOSI;
  wire        MISO;
  wire [15:0] data_line;
  wire [19:0] addr_line;
  wire chip_en_out, read_en_out, write_en_out, lb_en_out, ub_en_out;

  int errors = 0;
  int checks = 0;

  spi_top_module #(.MEM_CYCLES(MEM_CYCLES)) dut (
    .FPGA_clk(FPGA_clk), .FPGA_rst(FPGA_rst), .SCLK(SCLK), .SSEL(SSEL), .MOSI(MOSI),
    .MISO(MISO), .data_line(data_line), .addr_line(addr_line),
    .chip_en_out(chip_en_out), .read_en_out(read_en_out), .write_en_out(write_en_out),
    .lb_en_out(lb_en_out), .ub_en_out(ub_en_out)
  );

  always #5 FPGA_clk = ~FPGA_clk;

  // SRAM model: returns queued words whenever the read strobe is low.
  logic [15:0] mem_out = 16'h0;
  logic [15:0] rd_q[$];
  assign data_line = (read_en_out == 1'b0) ? mem_out : 16'hzzzz;
  always @(negedge read_en_out) if (rd_q.size() > 0) mem_out = rd_q.pop_front();

  // Strobe monitor: logs each chip-enable pulse and counts bus-rule violations.
  typedef struct { bit is_wr; logic [19:0] addr; logic [15:0] dat; int len; } ev_t;
  ev_t ev_q[$];
  ev_t cur;
  bit  in_strobe = 1'b0;
  int  viol = 0;
  always @(negedge FPGA_clk) begin
    if (chip_en_out === 1'b0) begin
      if (!in_strobe) begin
        in_strobe = 1'b1;
        cur.is_wr = (write_en_out === 1'b0);
        cur.addr  = addr_line;
        cur.dat   = data_line;
        cur.len   = 1;
      end else begin
        cur.len++;
      end
      if (lb_en_out !== 1'b0 || ub_en_out !== 1'b0 || write_en_out === read_en_out) viol++;
      if (addr_line !== cur.addr) viol++;
      if (write_en_out === 1'b0 && data_line !== cur.dat) viol++;
    end else begin
      if (in_strobe) begin
        in_strobe = 1'b0;
        ev_q.push_back(cur);
      end
      if (read_en_out !== 1'b1 || write_en_out !== 1'b1 || lb_en_out !== 1'b1 || ub_en_out !== 1'b1) viol++;
    end
    if (write_en_out !== 1'b0 && read_en_out !== 1'b0 && data_line !== 16'hzzzz) viol++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  logic        tx[$];
  logic        rx[$];
  logic [15:0] words[4];

  task automatic push_field(input logic [23:0] v, input int w);
    for (int i = w - 1; i >= 0; i--) tx.push_back(v[i]);
  endtask

  // Clock up to 'limit' bits of tx, capturing MISO just before each falling edge.
  task automatic clock_bits(input int limit);
    SSEL = 1'b0;
    #HP;
    for (int i = 0; i < tx.size() && i < limit; i++) begin
      MOSI = tx[i];
      SCLK = 1'b1;
      #HP;
      rx.push_back(MISO);
      SCLK = 1'b0;
      #HP;
    end
    SSEL = 1'b1;
    MOSI = 1'b0;
    #(4 * HP);
  endtask

  function automatic logic [31:0] rx_word(input int start, input int w);
    logic [31:0] v = '0;
    for (int b = 0; b < w; b++) v = {v[30:0], rx[start + b]};
    return v;
  endfunction

  task automatic check_idle_bus(input string tag);
    check({tag, "_strobes"}, {27'b0, chip_en_out, read_en_out, write_en_out, lb_en_out, ub_en_out}, 32'h1F);
    check({tag, "_bus_z"}, {16'h0, data_line}, {16'h0, 16'hzzzz});
    check({tag, "_miso0"}, {31'b0, MISO}, 32'h0);
  endtask

  task automatic clear_logs();
    tx.delete(); rx.delete(); rd_q.delete(); ev_q.delete(); viol = 0;
  endtask

  // One full frame; the expected memory cycles and MISO stream come from the command rules.
  task automatic do_frame(input string tag, input logic [7:0] cmd, input logic [23:0] addr, input int nw);
    bit is_wr, is_rd;
    int n;
    clear_logs();
    is_wr = (cmd[7:5] == 3'b111);
    is_rd = (cmd[7:5] == 3'b110);
    n = 0;
    if (is_wr || is_rd) n = BURST ? int'(cmd[2:0]) + 1 : 1;
    if (n > nw) n = nw;
    push_field({16'h0, cmd}, 8);
    push_field(addr, 24);
    for (int k = 0; k < nw; k++) begin
      push_field({8'h0, (is_rd ? 16'h0 : words[k])}, 16);
      if (is_rd) rd_q.push_back(words[k]);
    end
    clock_bits(tx.size());
    check($sformatf("%s_nstrobes", tag), ev_q.size(), n);
    for (int k = 0; k < n && k < ev_q.size(); k++) begin
      check($sformatf("%s_addr%0d", tag, k), {12'h0, ev_q[k].addr}, {12'h0, addr[19:0] + 20'(k)});
      check($sformatf("%s_kind%0d", tag, k), {31'b0, ev_q[k].is_wr}, {31'b0, is_wr});
      check($sformatf("%s_len%0d", tag, k), ev_q[k].len, MEM_CYCLES);
      if (is_wr) check($sformatf("%s_wdat%0d", tag, k), {16'h0, ev_q[k].dat}, {16'h0, words[k]});
    end
    check($sformatf("%s_miso_hdr", tag), rx_word(0, 32), 32'h0);
    for (int k = 0; k < nw; k++)
      check($sformatf("%s_miso%0d", tag, k), rx_word(32 + 16 * k, 16),
            {16'h0, ((is_rd && k < n) ? words[k] : 16'h0)});
    check($sformatf("%s_viol", tag), viol, 0);
    check_idle_bus(tag);
  endtask

  initial begin
    SCLK = 1'b0; SSEL = 1'b1; MOSI = 1'b0; FPGA_rst = 1'b1;
    #100;
    check("rst_addr", {12'h0, addr_line}, 32'h0);
    check_idle_bus("rst");
    FPGA_rst = 1'b0;
    #100;
    viol = 0;

    words[0] = 16'h5555;
    do_frame("wr_basic", 8'hE0, 24'h555555, 1);
    words[0] = 16'h03E8;
    do_frame("rd_basic", 8'hC0, 24'h000000, 1);
    words[0] = 16'h5555; words[1] = 16'h0000; words[2] = 16'hFFFF;
    do_frame("wr_burst", 8'hE2, 24'h000010, 3);
    words[0] = 16'd100; words[1] = 16'd200; words[2] = 16'd300;
    do_frame("rd_burst", 8'hC2, 24'h0FFFFF, 3);

    // Deselect after 20 bits of a write frame.
    clear_logs();
    push_field(24'hE0, 8); push_field(24'h0000AA, 24); push_field(24'h1234, 16);
    clock_bits(20);
    check("abort_nstrobes", ev_q.size(), 0);
    check("abort_viol", viol, 0);
    check_idle_bus("abort");

    // Reset while a read strobe is in flight.
    clear_logs();
    push_field(24'hC0, 8); push_field(24'h000123, 24);
    rd_q.push_back(16'hBEEF);
    SSEL = 1'b0;
    #HP;
    for (int i = 0; i < 32; i++) begin
      MOSI = tx[i]; SCLK = 1'b1; #HP; SCLK = 1'b0;
      if (i < 31) #HP;
    end
    for (int c = 0; c < 20 && read_en_out !== 1'b0; c++) @(negedge FPGA_clk);
    check("rstmid_strobe_seen", {31'b0, read_en_out}, 32'h0);
    FPGA_rst = 1'b1;
    @(posedge FPGA_clk);
    #1;
    check("rstmid_addr", {12'h0, addr_line}, 32'h0);
    check_idle_bus("rstmid");
    #63;
    FPGA_rst = 1'b0;
    for (int i = 0; i < 16; i++) begin
      MOSI = 1'b1; SCLK = 1'b1; #HP; rx.push_back(MISO); SCLK = 1'b0; #HP;
    end
    SSEL = 1'b1; MOSI = 1'b0;
    #(4 * HP);
    check("rstmid_nstrobes", ev_q.size(), 1);
    if (ev_q.size() > 0) check("rstmid_cut_short", {31'b0, (ev_q[0].len < MEM_CYCLES)}, 32'h1);
    check("rstmid_miso", rx_word(0, 16), 32'h0);
    check_idle_bus("rstmid_after");

    words[0] = 16'hA5C3;
    do_frame("wr_after", 8'hE0, 24'h0ABCDE, 1);
    words[0] = 16'h1111; words[1] = 16'h2222;
    do_frame("bad_op", 8'hA0, 24'h123456, 1);

    for (int r = 0; r < 6; r++) begin
      int bl;
      logic [2:0] op;
      bl = $urandom_range(0, 3);
      op = ($urandom_range(0, 1) == 1) ? 3'b111 : 3'b110;
      for (int k = 0; k < 4; k++) words[k] = 16'($urandom);
      do_frame($sformatf("rnd%0d", r), {op, 2'($urandom_range(0, 3)), 3'(bl)}, 24'($urandom), bl + 1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/spi_top_module.md
SPI_TOP_MODULE -- requirements
Module: spi_top_module

Interface
REQ-001 SHALL have parameter MEM_CYCLES, default 3, FPGA_clk cycles each memory strobe stays asserted.
REQ-002 SHALL have port FPGA_clk, input, 1, the single system clock; all logic on its rising edge.
REQ-003 SHALL have port FPGA_rst, input, 1, reset, synchronous and active-high.
REQ-004 SHALL have ports SCLK / SSEL / MOSI, input, 1 each, SPI clock, active-low select, and master data.
REQ-005 SHALL have port MISO, output, 1, slave data.
REQ-006 SHALL have port data_line, inout, 16, memory data bus.
REQ-007 SHALL have port addr_line, output, 20, memory address.
REQ-008 SHALL have ports chip_en_out / read_en_out / write_en_out / lb_en_out / ub_en_out, output, 1 each, active-low memory strobes.

Function
REQ-009 SHALL pass SCLK, SSEL and MOSI through 2-flop synchronizers and edge-detect SCLK in the FPGA_clk domain; FPGA_clk ≥ 8× SCLK frequency.
REQ-010 SHALL sample MOSI on SCLK falling edges and update MISO on SCLK rising edges, MSB first, only while SSEL = 0.
REQ-011 SHALL interpret the frame as an 8-bit command, then a 24-bit address, then 16-bit data words.
REQ-012 Command bits [7:5] SHALL be 111 for write and 110 for read; [4:3] burst_ctrl (reserved, ignored); [2:0] burst_len; words per frame = burst_len+1.
REQ-013 Any other opcode SHALL idle the FSM until SSEL rises; no strobes are issued.
REQ-014 addr_line SHALL be the low 20 bits of the received address, and SHALL increment by 1 (wrapping at 0xFFFFF) after each word of a burst.
REQ-015 SHALL use FSM states IDLE, CMD, ADDR, WDATA, WSTROBE, RSTROBE, RSHIFT, DONE.
REQ-016 Write flow: after the 16th data bit of a word, state WSTROBE drives data_line with the word and asserts chip_en_out, write_en_out, lb_en_out and ub_en_out low for MEM_CYCLES clocks.
REQ-017 After WSTROBE, the FSM SHALL return to WDATA if words remain, otherwise go to DONE.
REQ-018 Read flow: after the 32nd frame bit, state RSTROBE releases data_line, asserts chip_en_out, read_en_out, lb_en_out and ub_en_out low for MEM_CYCLES clocks, and latches data_line on the last strobe clock.
REQ-019 State RSHIFT SHALL shift the latched word out on MISO over the next 16 SCLK cycles, then repeat RSTROBE at the next address while words remain.
REQ-020 data_line SHALL be high-Z except during WSTROBE.
REQ-021 MISO SHALL be 0 when not in RSHIFT.
REQ-022 Strobes SHALL never overlap between words; all strobes are high outside the STROBE states.
REQ-023 SSEL rising mid-frame SHALL abort to IDLE within 3 clocks, strobes deasserted and data_line released; an in-progress strobe is cut short.
REQ-024 SSEL falling SHALL restart bit counting at command bit 7.

Reset
REQ-025 While FPGA_rst = 1, the FSM SHALL be IDLE, counters and shift registers 0, addr_line 0, MISO 0, all strobes 1, and data_line high-Z.
REQ-026 Reset asserted mid-operation SHALL override everything on the next clock edge.

Configuration
REQ-027 With SPI_BURST_EN defined, burst_len SHALL be honoured as in REQ-012.
REQ-028 Without SPI_BURST_EN, burst_len SHALL be ignored, every frame moves exactly one word, and no address increment logic is built.

Verification
REQ-029 Write: cmd 0xE0, addr 0x555555, data 0x5555 -> one write strobe of MEM_CYCLES clocks, addr_line 0x55555, data_line 0x5555, all strobes high afterwards.
REQ-030 Read: cmd 0xC0, addr 0x000000, bench drives data_line 0x03E8 -> one read strobe, addr_line 0x00000, MISO shifts 0x03E8 MSB first.
REQ-031 Burst write (SPI_BURST_EN): cmd 0xE2, addr 0x000010, words 0x5555/0x0000/0xFFFF -> three write strobes at addresses 0x10, 0x11, 0x12 with the matching data.
REQ-032 Burst read (SPI_BURST_EN): cmd 0xC2, addr 0x0FFFFF, memory returns 100/200/300 -> addresses 0xFFFFF, 0x00000, 0x00001 and MISO shows 0x0064, 0x00C8, 0x012C.
REQ-033 Abort/reset: SSEL high after 20 bits, and separately FPGA_rst high during RSTROBE -> no further strobes, data_line high-Z, next frame with cmd 0xE0 works normally.
REQ-034 Invalid opcode 0xA0 followed by 40 bits -> no strobes, MISO 0 for the whole frame.
